// File: rtl/chroni_vram_responder.sv
// VRAM responder for chroni video fetches: fixed-latency byte reads over rd_req/rd_ack,
// one-deep pending slot for early requests, and CPU byte writes in cycles with no read accept.
module chroni_vram_responder #(
    parameter int unsigned MEM_ADDR_W   = 14,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [12:0]           addr_in,
    input  logic [7:0]            addr_in_page,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [7:0]            data_out,
    input  logic                  cpu_wr_req,
    input  logic [MEM_ADDR_W-1:0] cpu_addr,
    input  logic [7:0]            cpu_data,
    output logic                  cpu_wr_ack,
    output logic                  rd_overrun
);

    localparam int unsigned LIN_W    = 21;
    localparam logic [2:0]  CNT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [LIN_W-1:0]   pend_addr_q, pend_addr_d;
    logic               oor_q, oor_d;
    logic [7:0]         hold_q, hold_d;
    logic               cpu_wr_ack_q, cpu_wr_ack_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         rdata_q;

    logic [LIN_W-1:0]   live_addr;
    logic [LIN_W-1:0]   acc_addr;
    logic               acc;
    logic               acc_oor;
    logic               ram_rd_en;
    logic               wr_commit;

    logic [7:0] mem [2**MEM_ADDR_W];

    // Accept slot arbitration: the pending request always goes before a live one.
    always_comb begin
        live_addr   = {addr_in_page, addr_in};
        acc         = 1'b0;
        acc_addr    = live_addr;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        overrun_d   = overrun_q;
        if (state_q != BUSY) begin
            if (pend_q) begin
                acc      = 1'b1;
                acc_addr = pend_addr_q;
                pend_d   = rd_req;
                if (rd_req) begin
                    pend_addr_d = live_addr;
                end
            end else if (rd_req) begin
                acc = 1'b1;
            end
        end else if (rd_req) begin
            if (!pend_q) begin
                pend_d      = 1'b1;
                pend_addr_d = live_addr;
            end else begin
                overrun_d = 1'b1;
            end
        end
        acc_oor      = (acc_addr >> MEM_ADDR_W) != '0;
        oor_d        = acc ? acc_oor : oor_q;
        ram_rd_en    = acc && !acc_oor;
        // A write is blocked while its own ack is showing so a held request commits once.
        wr_commit    = cpu_wr_req && !acc && !cpu_wr_ack_q;
        cpu_wr_ack_d = wr_commit;
    end

    // Counter holds READ_LATENCY-1 after accept; ACK follows the cycle it decrements to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (acc) begin
            cnt_d   = CNT_LOAD;
            state_d = (READ_LATENCY == 1) ? ACK : BUSY;
        end else begin
            case (state_q)
                BUSY: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ACK;
                    end
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ack     = (state_q == ACK);
        data_out   = rd_ack ? (oor_q ? '0 : rdata_q) : hold_q;
        hold_d     = data_out;
        cpu_wr_ack = cpu_wr_ack_q;
        rd_overrun = overrun_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            oor_q        <= 1'b0;
            hold_q       <= '0;
            cpu_wr_ack_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            oor_q        <= oor_d;
            hold_q       <= hold_d;
            cpu_wr_ack_q <= cpu_wr_ack_d;
            overrun_q    <= overrun_d;
        end
    end

    // Single port: a read accept and a write commit are mutually exclusive by construction.
    always_ff @(posedge vga_clk) begin
        if (ram_rd_en) begin
            rdata_q <= mem[acc_addr[MEM_ADDR_W-1:0]];
        end else if (wr_commit) begin
            mem[cpu_addr] <= cpu_data;
        end
    end

endmodule

// File: tb/tb_chroni_vram_responder.sv
// Directed bench for chroni_vram_responder: a READ_LATENCY=2 instance plus a READ_LATENCY=1 instance.
module tb_chroni_vram_responder;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [12:0] addr_in;
    logic [7:0]  page;
    logic        rd_req;
    logic        rd_ack;
    logic [7:0]  data_out;
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        overrun;

    logic [12:0] addr_in_1;
    logic        rd_req_1;
    logic        rd_ack_1;
    logic [7:0]  data_out_1;
    logic        wr_req_1;
    logic [13:0] wr_addr_1;
    logic [7:0]  wr_data_1;
    logic        wr_ack_1;
    logic        overrun_1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chroni_vram_responder #(.MEM_ADDR_W(14), .READ_LATENCY(2)) dut (
        .vga_clk(clk), .reset_n(reset_n),
        .addr_in(addr_in), .addr_in_page(page), .rd_req(rd_req),
        .rd_ack(rd_ack), .data_out(data_out),
        .cpu_wr_req(wr_req), .cpu_addr(wr_addr), .cpu_data(wr_data),
        .cpu_wr_ack(wr_ack), .rd_overrun(overrun)
    );

    chroni_vram_responder #(.MEM_ADDR_W(14), .READ_LATENCY(1)) dut1 (
        .vga_clk(clk), .reset_n(reset_n),
        .addr_in(addr_in_1), .addr_in_page(8'h00), .rd_req(rd_req_1),
        .rd_ack(rd_ack_1), .data_out(data_out_1),
        .cpu_wr_req(wr_req_1), .cpu_addr(wr_addr_1), .cpu_data(wr_data_1),
        .cpu_wr_ack(wr_ack_1), .rd_overrun(overrun_1)
    );

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        adv();
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 6 && !got; i++) begin
            smp();
            if (wr_ack === 1'b1) got = 1'b1;
            else adv();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wr_ack_timeout addr=%h: got no ack want ack", a);
        end
        adv();
        wr_req = 1'b0;
    endtask

    task automatic do_write1(input logic [13:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        adv();
        wr_req_1 = 1'b1; wr_addr_1 = a; wr_data_1 = d;
        for (int i = 0; i < 6 && !got; i++) begin
            smp();
            if (wr_ack_1 === 1'b1) got = 1'b1;
            else adv();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wr1_ack_timeout addr=%h: got no ack want ack", a);
        end
        adv();
        wr_req_1 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rd_req = 1'b0; addr_in = '0; page = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_1 = 1'b0; addr_in_1 = '0;
        wr_req_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0;
        repeat (3) @(posedge clk);
        smp();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (rd_ack_1 !== 1'b0 || data_out_1 !== 8'h00) begin
            failures++; $display("FAIL reset_dut1: got ack=%b data=%h want 0/00", rd_ack_1, data_out_1);
        end
        adv();
        reset_n = 1'b1;
    endtask

    task automatic test_read_basic();
        do_write(14'h0401, 8'h41);
        do_write(14'h0208, 8'h5A);
        adv(); rd_req = 1'b1; page = 8'h00; addr_in = 13'h0401;
        smp();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_T0: got %b want 0", rd_ack); end
        adv(); rd_req = 1'b0;
        smp();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_T1: got %b want 0", rd_ack); end
        adv(); rd_req = 1'b1; addr_in = 13'h0208;
        smp();
        checks++; if (rd_ack !== 1'b1 || data_out !== 8'h41) begin
            failures++; $display("FAIL basic_ack_T2: got ack=%b data=%h want 1/41", rd_ack, data_out);
        end
        adv(); rd_req = 1'b0;
        smp();
        checks++; if (rd_ack !== 1'b0 || data_out !== 8'h41) begin
            failures++; $display("FAIL basic_hold_T3: got ack=%b data=%h want 0/41", rd_ack, data_out);
        end
        adv();
        smp();
        checks++; if (rd_ack !== 1'b1 || data_out !== 8'h5A) begin
            failures++; $display("FAIL b2b_ack_T4: got ack=%b data=%h want 1/5a", rd_ack, data_out);
        end
        adv();
        smp();
        checks++; if (rd_ack !== 1'b0 || data_out !== 8'h5A) begin
            failures++; $display("FAIL b2b_hold_T5: got ack=%b data=%h want 0/5a", rd_ack, data_out);
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_pipeline();
        logic        req_t [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [12:0] adr_t [8] = '{13'h10, 13'h11, 13'h12, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
        logic        ack_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  dat_t [8] = '{8'h5A, 8'h5A, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        do_write(14'h0010, 8'h11);
        do_write(14'h0011, 8'h22);
        do_write(14'h0012, 8'h33);
        for (int i = 0; i < 8; i++) begin
            adv(); rd_req = req_t[i]; addr_in = adr_t[i]; page = 8'h00;
            smp();
            checks++; if (rd_ack !== ack_t[i]) begin
                failures++; $display("FAIL pipe_ack[%0d]: got %b want %b", i, rd_ack, ack_t[i]);
            end
            checks++; if (data_out !== dat_t[i]) begin
                failures++; $display("FAIL pipe_data[%0d]: got %h want %h", i, data_out, dat_t[i]);
            end
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL pipe_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        logic        req_t [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [12:0] adr_t [10] = '{13'h10, 13'h11, 13'h12, 13'h13, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
        logic        ack_t [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0]  dat_t [10] = '{8'h33, 8'h33, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
        logic        ovr_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            adv(); rd_req = req_t[i]; addr_in = adr_t[i]; page = 8'h00;
            smp();
            checks++; if (rd_ack !== ack_t[i]) begin
                failures++; $display("FAIL ovr_ack[%0d]: got %b want %b", i, rd_ack, ack_t[i]);
            end
            checks++; if (data_out !== dat_t[i]) begin
                failures++; $display("FAIL ovr_data[%0d]: got %h want %h", i, data_out, dat_t[i]);
            end
            checks++; if (overrun !== ovr_t[i]) begin
                failures++; $display("FAIL ovr_flag[%0d]: got %b want %b", i, overrun, ovr_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        adv(); rd_req = 1'b1; page = 8'h00; addr_in = 13'h0401;
        smp();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rst_ack_T0: got %b want 0", rd_ack); end
        adv(); rd_req = 1'b0;
        #2; reset_n = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00 || rd_ack !== 1'b0) begin
            failures++; $display("FAIL rst_async_outputs: got ack=%b data=%h want 0/00", rd_ack, data_out);
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_async_overrun: got %b want 0", overrun); end
        adv(); adv();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rst_dropped_ack[%0d]: got %b want 0", i, rd_ack); end
            adv();
        end
        rd_req = 1'b1; addr_in = 13'h0010;
        smp();
        adv(); rd_req = 1'b0;
        smp();
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL rst_after_T1: got %b want 0", rd_ack); end
        adv();
        smp();
        checks++; if (rd_ack !== 1'b1 || data_out !== 8'h11) begin
            failures++; $display("FAIL rst_after_T2: got ack=%b data=%h want 1/11", rd_ack, data_out);
        end
    endtask

    task automatic test_wr_conflict();
        adv(); rd_req = 1'b1; page = 8'h00; addr_in = 13'h0020;
        wr_req = 1'b1; wr_addr = 14'h0030; wr_data = 8'h77;
        smp();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL conf_wr_ack_T0: got %b want 0", wr_ack); end
        adv(); rd_req = 1'b0;
        smp();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL conf_wr_ack_T1: got %b want 0", wr_ack); end
        adv();
        smp();
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL conf_wr_ack_T2: got %b want 1", wr_ack); end
        checks++; if (rd_ack !== 1'b1) begin failures++; $display("FAIL conf_rd_ack_T2: got %b want 1", rd_ack); end
        adv(); wr_req = 1'b0;
        smp();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL conf_wr_ack_T3: got %b want 0", wr_ack); end
        adv(); rd_req = 1'b1; addr_in = 13'h0030;
        smp();
        adv(); rd_req = 1'b0;
        smp();
        adv();
        smp();
        checks++; if (rd_ack !== 1'b1 || data_out !== 8'h77) begin
            failures++; $display("FAIL conf_readback: got ack=%b data=%h want 1/77", rd_ack, data_out);
        end
    endtask

    task automatic test_out_of_range();
        adv(); rd_req = 1'b1; page = 8'h02; addr_in = 13'h0000;
        smp();
        adv(); rd_req = 1'b0; page = 8'h00;
        smp();
        checks++; if (rd_ack !== 1'b0 || data_out !== 8'h77) begin
            failures++; $display("FAIL oor_T1: got ack=%b data=%h want 0/77", rd_ack, data_out);
        end
        adv();
        smp();
        checks++; if (rd_ack !== 1'b1 || data_out !== 8'h00) begin
            failures++; $display("FAIL oor_T2: got ack=%b data=%h want 1/00", rd_ack, data_out);
        end
        adv();
        smp();
        checks++; if (rd_ack !== 1'b0 || data_out !== 8'h00) begin
            failures++; $display("FAIL oor_T3: got ack=%b data=%h want 0/00", rd_ack, data_out);
        end
    endtask

    task automatic test_latency1();
        logic        req_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [12:0] adr_t [5] = '{13'h1, 13'h2, 13'h3, 13'h0, 13'h0};
        logic        ack_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  dat_t [5] = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA3};
        do_write1(14'h0001, 8'hA1);
        do_write1(14'h0002, 8'hA2);
        do_write1(14'h0003, 8'hA3);
        for (int i = 0; i < 5; i++) begin
            adv(); rd_req_1 = req_t[i]; addr_in_1 = adr_t[i];
            smp();
            checks++; if (rd_ack_1 !== ack_t[i]) begin
                failures++; $display("FAIL lat1_ack[%0d]: got %b want %b", i, rd_ack_1, ack_t[i]);
            end
            checks++; if (data_out_1 !== dat_t[i]) begin
                failures++; $display("FAIL lat1_data[%0d]: got %h want %h", i, data_out_1, dat_t[i]);
            end
        end
        checks++; if (overrun_1 !== 1'b0) begin failures++; $display("FAIL lat1_overrun: got %b want 0", overrun_1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_pipeline();
        test_overrun();
        test_reset_mid_read();
        test_wr_conflict();
        test_out_of_range();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
